// File: rtl/ps2_pkg.sv
// Shared types, constants and the speed saturation helper for the PS/2 paddle decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  localparam int unsigned FRAME_BITS   = 11;
  localparam int unsigned PACKET_BYTES = 3;

  localparam int unsigned FLAG_ALWAYS1 = 3;
  localparam int unsigned FLAG_YSIGN   = 5;
  localparam int unsigned FLAG_YOVF    = 7;

  localparam int unsigned SPEED_MAX = 255;

  // |{sign, y}| as 9-bit two's complement, clamped to 8 bits; overflow forces full scale.
  function automatic logic [7:0] sat_speed(input logic sign, input logic ovf,
                                           input logic [7:0] y_byte);
    logic [8:0] y;
    logic [8:0] mag;
    y   = {sign, y_byte};
    mag = sign ? (~y + 9'd1) : y;
    if (ovf || mag[8]) return 8'(SPEED_MAX);
    return mag[7:0];
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 byte receiver: synchronizer, optional clock glitch filter (PS2_GLITCH_FILTER_EN),
// 11-bit frame FSM with odd parity check, and inactivity timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  input  logic       i_pkt_busy,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_byte_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_LEN < 2) begin : g_bad_param
    $error("ps2_frame_rx: SYNC_STAGES must be 2..4 and FILTER_LEN at least 2");
  end

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   w_clk_lvl;
  logic                   w_data;
  logic                   w_sample;
  logic                   w_busy;
  logic                   w_timeout;

  frame_state_t r_state;
  frame_state_t w_next;
  logic [7:0]   r_shift;
  logic [2:0]   r_bit_cnt;
  logic         r_parity;
  logic [TO_W-1:0] r_to_cnt;

  // Lines idle high, so the chain resets high to avoid a false edge after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
    end
  end

  assign w_data = r_data_sync[SYNC_STAGES-1];

`ifdef PS2_GLITCH_FILTER_EN
  localparam int unsigned FL_W = $clog2(FILTER_LEN + 1);

  logic            r_filt;
  logic [FL_W-1:0] r_filt_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_sync[SYNC_STAGES-1] == r_filt) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FL_W'(FILTER_LEN - 1)) begin
      r_filt     <= r_clk_sync[SYNC_STAGES-1];
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  assign w_clk_lvl = r_filt;
`else
  assign w_clk_lvl = r_clk_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_clk_prev <= 1'b1;
    else       r_clk_prev <= w_clk_lvl;
  end

  assign w_sample  = r_clk_prev & ~w_clk_lvl;
  assign w_busy    = (r_state != IDLE) || i_pkt_busy;
  assign w_timeout = !w_sample && w_busy && (r_to_cnt >= TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_byte_valid = 1'b0;
    o_byte_err   = 1'b0;
    if (w_sample) begin
      case (r_state)
        IDLE: begin
          if (!w_data) w_next = DATA;
          else         o_byte_err = 1'b1;
        end
        DATA: begin
          if (r_bit_cnt == 3'(FRAME_BITS - 4)) w_next = PARITY;
        end
        PARITY: w_next = STOP;
        STOP: begin
          w_next = IDLE;
          if (w_data && (^{r_shift, r_parity})) o_byte_valid = 1'b1;
          else                                  o_byte_err   = 1'b1;
        end
        default: w_next = IDLE;
      endcase
    end else if (w_timeout) begin
      w_next     = IDLE;
      o_byte_err = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      if (w_sample) begin
        r_to_cnt <= '0;
        case (r_state)
          IDLE:    r_bit_cnt <= '0;
          DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY:  r_parity <= w_data;
          default: ;
        endcase
      end else if (w_timeout || !w_busy) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign o_byte_data = r_shift;

endmodule

// File: rtl/ps2_paddle_decoder.sv
// Assembles 3-byte PS/2 mouse packets into paddle speed/direction commands.
// Optional build macro: PS2_GLITCH_FILTER_EN (ps2_clk stability filter).
module ps2_paddle_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk_25MHz,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] paddle0_speed,
  output logic       paddle0_dir,
  output logic       new_data,
  output logic       frame_err
);

  logic       w_byte_valid;
  logic [7:0] w_byte_data;
  logic       w_byte_err;
  logic [1:0] r_byte_idx;
  logic       r_ysign;
  logic       r_yovf;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_LEN    (FILTER_LEN)
  ) u_frame_rx (
    .i_clk       (clk_25MHz),
    .i_rst       (reset),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_data  (ps2_data),
    .i_pkt_busy  (r_byte_idx != 2'd0),
    .o_byte_valid(w_byte_valid),
    .o_byte_data (w_byte_data),
    .o_byte_err  (w_byte_err)
  );

  always_ff @(posedge clk_25MHz) begin
    if (reset) begin
      paddle0_speed <= '0;
      paddle0_dir   <= 1'b0;
      new_data      <= 1'b0;
      frame_err     <= 1'b0;
      r_byte_idx    <= '0;
      r_ysign       <= 1'b0;
      r_yovf        <= 1'b0;
    end else begin
      new_data  <= 1'b0;
      frame_err <= 1'b0;
      if (w_byte_err) begin
        r_byte_idx <= '0;
        frame_err  <= 1'b1;
      end else if (w_byte_valid) begin
        if (r_byte_idx == 2'd0) begin
          // A flags byte without the always-one bit is dropped so the stream realigns.
          if (w_byte_data[FLAG_ALWAYS1]) begin
            r_ysign    <= w_byte_data[FLAG_YSIGN];
            r_yovf     <= w_byte_data[FLAG_YOVF];
            r_byte_idx <= 2'd1;
          end else begin
            frame_err <= 1'b1;
          end
        end else if (r_byte_idx == 2'(PACKET_BYTES - 1)) begin
          r_byte_idx    <= '0;
          paddle0_speed <= sat_speed(r_ysign, r_yovf, w_byte_data);
          paddle0_dir   <= r_ysign;
          new_data      <= 1'b1;
        end else begin
          r_byte_idx <= r_byte_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_paddle_decoder.sv
// Directed bench for ps2_paddle_decoder: drives PS/2 frames and checks decoded packets.
module tb_ps2_paddle_decoder;

  logic       clk_25MHz = 1'b0;
  logic       reset     = 1'b1;
  logic       ps2_clk   = 1'b1;
  logic       ps2_data  = 1'b1;
  logic [7:0] paddle0_speed;
  logic       paddle0_dir;
  logic       new_data;
  logic       frame_err;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned nd_cnt = 0;
  int unsigned fe_cnt = 0;
  int unsigned nd_run = 0;
  int unsigned nd_max_run = 0;
  int unsigned nd_base;
  int unsigned fe_base;

  ps2_paddle_decoder #(
    .TIMEOUT_CYCLES(500)
  ) dut (
    .clk_25MHz    (clk_25MHz),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .paddle0_speed(paddle0_speed),
    .paddle0_dir  (paddle0_dir),
    .new_data     (new_data),
    .frame_err    (frame_err)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  always @(negedge clk_25MHz) begin
    if (new_data) begin
      nd_cnt++;
      nd_run++;
      if (nd_run > nd_max_run) nd_max_run = nd_run;
    end else begin
      nd_run = 0;
    end
    if (frame_err) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk_25MHz);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cycles(25);
    ps2_clk = 1'b0;
    cycles(50);
    ps2_clk = 1'b1;
    cycles(25);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_parity);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ bad_parity);
    send_bit(1'b1);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
    cycles(20);
  endtask

  task automatic mark();
    nd_base = nd_cnt;
    fe_base = fe_cnt;
  endtask

  task automatic expect_packet(input string tag, input logic [7:0] spd, input logic dir);
    check({tag, "_new_data_count"}, nd_cnt - nd_base, 1);
    check({tag, "_frame_err_count"}, fe_cnt - fe_base, 0);
    check({tag, "_speed"}, {24'd0, paddle0_speed}, {24'd0, spd});
    check({tag, "_dir"}, {31'd0, paddle0_dir}, {31'd0, dir});
  endtask

  initial begin
    cycles(5);
    @(negedge clk_25MHz);
    check("reset_speed", {24'd0, paddle0_speed}, 0);
    check("reset_dir", {31'd0, paddle0_dir}, 0);
    check("reset_new_data", {31'd0, new_data}, 0);
    check("reset_frame_err", {31'd0, frame_err}, 0);
    reset = 1'b0;
    cycles(10);

    mark(); send_packet(8'h08, 8'h00, 8'h05); expect_packet("pos5", 8'd5, 1'b0);
    mark(); send_packet(8'h28, 8'h10, 8'hFB); expect_packet("neg5", 8'd5, 1'b1);
    mark(); send_packet(8'h28, 8'h00, 8'h00); expect_packet("neg256", 8'd255, 1'b1);
    mark(); send_packet(8'hA8, 8'h00, 8'h02); expect_packet("ovf", 8'd255, 1'b1);

    mark();
    send_byte(8'h08, 1'b0);
    send_byte(8'h00, 1'b1);
    cycles(20);
    check("bad_parity_frame_err", fe_cnt - fe_base, 1);
    check("bad_parity_no_new_data", nd_cnt - nd_base, 0);
    mark(); send_packet(8'h08, 8'h00, 8'h03); expect_packet("after_parity", 8'd3, 1'b0);

    mark();
    send_byte(8'h00, 1'b0);
    send_packet(8'h08, 8'h00, 8'h07);
    check("realign_frame_err", fe_cnt - fe_base, 1);
    check("realign_new_data", nd_cnt - nd_base, 1);
    check("realign_speed", {24'd0, paddle0_speed}, 7);

    mark(); send_packet(8'h08, 8'h00, 8'h00); expect_packet("zero", 8'd0, 1'b0);

    mark();
    send_byte(8'h08, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    cycles(600);
    check("timeout_frame_err", fe_cnt - fe_base, 1);
    check("timeout_no_new_data", nd_cnt - nd_base, 0);
    check("timeout_hold_speed", {24'd0, paddle0_speed}, 0);
    mark(); send_packet(8'h08, 8'h00, 8'h7F); expect_packet("after_timeout", 8'd127, 1'b0);

    mark();
    send_byte(8'h28, 1'b0);
    send_byte(8'h00, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    cycles(5);
    reset = 1'b0;
    cycles(300);
    check("reset_mid_no_new_data", nd_cnt - nd_base, 0);
    check("reset_mid_speed", {24'd0, paddle0_speed}, 0);
    check("reset_mid_dir", {31'd0, paddle0_dir}, 0);

    check("new_data_max_width", nd_max_run, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_paddle_decoder.md
Name: ps2_paddle_decoder

Overview:
Receives PS/2 mouse traffic (clock and data lines from the connector) and turns each 3-byte movement packet into the paddle command consumed by Physics_top.
- Outputs: paddle0_speed, paddle0_dir and a one-cycle new_data strobe.
- This block is the producing end of the physics input interface.
- Each packet is 33 bits on the wire; new_data fires once per valid packet.

Parameters:
- TIMEOUT_CYCLES, 5000: clk_25MHz cycles with no ps2_clk falling edge before partial frame/packet state is discarded (200 us).
- SYNC_STAGES, 2: flip-flop stages synchronizing ps2_clk and ps2_data; legal values 2..4.
- FILTER_LEN, 8: cycles a synchronized ps2_clk level must stay stable to be accepted (used only with PS2_GLITCH_FILTER_EN).

Ports:
- clk_25MHz  in  1  system clock, 25 MHz.
- reset  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk_25MHz.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk_25MHz.
- paddle0_speed  out  8  movement magnitude of the last valid packet.
- paddle0_dir  out  1  direction of the last valid packet; 0 = Y positive (up), 1 = Y negative.
- new_data  out  1  one-cycle strobe; paddle0_speed/paddle0_dir are updated in the same cycle.
- frame_err  out  1  one-cycle strobe on any discarded byte or packet.

Behaviour:
- One clock, clk_25MHz. Reset is synchronous and active-high, and has priority over all other activity.
- Reset values: paddle0_speed = 0, paddle0_dir = 0, new_data = 0, frame_err = 0, FSM = IDLE, byte_idx = 0, timeout counter = 0.
- Synchronization: both lines pass through SYNC_STAGES flip-flops.
  - A falling edge of the synchronized ps2_clk is a "sample" event.
  - ps2_data is sampled in that same cycle.
- Frame FSM (one 11-bit byte):
  - IDLE: on sample, if data = 0 go to DATA with bit_cnt = 0; if data = 1, raise frame_err and stay in IDLE.
  - DATA: on each sample, shift data into the byte LSB first and increment bit_cnt. After the 8th bit, go to PARITY.
  - PARITY: on sample, store the bit and go to STOP. Odd parity is required: the XOR of the 8 data bits and the parity bit must be 1.
  - STOP: on sample, the byte is good if stop = 1 and parity is OK. Then go to IDLE. A bad byte raises frame_err and forces byte_idx = 0.
- Packet assembly, byte_idx 0..2:
  - Byte 0 is flags. Bit 3 must be 1, otherwise frame_err and byte_idx stays at 0 (realignment). Keep bit 5 (Y sign) and bit 7 (Y overflow).
  - Byte 1 is X movement; it is ignored but still counted.
  - Byte 2 is Y movement. On a good byte 2: byte_idx returns to 0 and the outputs are registered.
- Output registration, on the cycle after the STOP sample of a good byte 2:
  - Y = {sign, byte2}, 9-bit two's complement.
  - paddle0_dir = sign.
  - paddle0_speed = |Y|, saturated to 255. This covers -256 → 255, and any packet with the overflow bit set → 255.
  - new_data = 1 for exactly that cycle.
  - Outputs hold until the next valid packet.
- Latency: 1 cycle from the final sample to new_data. The new_data strobe never lasts more than one cycle.
- Timeout:
  - The counter increments every cycle outside IDLE with byte_idx = 0, and clears on every sample.
  - Reaching TIMEOUT_CYCLES sets FSM = IDLE, byte_idx = 0 and raises frame_err. The outputs are not changed.
  - A sample and a timeout in the same cycle: the sample wins.
- Reset mid-frame or mid-packet discards everything. No new_data is produced for a packet that straddles reset.
- Y = 0 is still a valid packet: new_data = 1, speed = 0, dir = sign.

Optional Feature:
- Macro: PS2_GLITCH_FILTER_EN.
- Defined: the synchronized ps2_clk feeds a stability filter. The filtered level changes only after FILTER_LEN consecutive identical samples; edges are detected on the filtered level, and ps2_data is sampled at the filtered falling edge. Pulses shorter than FILTER_LEN cycles are ignored.
- Undefined: edges are taken directly from the synchronizer output. FILTER_LEN is unused, and latency is reduced by FILTER_LEN cycles.

Decomposition:
- Package ps2_pkg:
  - frame FSM state enum (IDLE, DATA, PARITY, STOP);
  - FRAME_BITS = 11 and PACKET_BYTES = 3;
  - flag bit indices: FLAG_ALWAYS1 = 3, FLAG_YSIGN = 5, FLAG_YOVF = 7;
  - SPEED_MAX = 255.
- Sub-module ps2_frame_rx: synchronizer, optional filter, frame FSM, parity and timeout. It emits byte_valid, byte_data[7:0] and byte_err.
- ps2_paddle_decoder: packet assembly, saturation and output registers.

Test Plan:
- Bench drives ps2_clk with a 50-cycle half period and TIMEOUT_CYCLES = 500.
- Packet 0x08, 0x00, 0x05 → one new_data pulse, speed = 5, dir = 0.
- Packet 0x28, 0x10, 0xFB (Y = -5) → speed = 5, dir = 1. Packet 0x28, 0x00, 0x00 (Y = -256) → speed = 255, dir = 1.
- Packet 0xA8, 0x00, 0x02 (overflow set) → speed = 255, dir = 1.
- Byte 1 sent with wrong parity → frame_err pulse and no new_data. A following good packet 0x08, 0x00, 0x03 → speed = 3.
- Leading byte 0x00 (bit 3 clear), then packet 0x08, 0x00, 0x07 → one frame_err, then speed = 7 with exactly one new_data.
- Stop mid-packet after 5 bits and idle 600 cycles → frame_err. The next full packet decodes correctly. Reset asserted during byte 2 → no new_data and all outputs 0.
